// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_access_ctrl
//  Description : Initiator-side sequencer owning the port of a 2-read/1-write
//                register file. Accepts write / read-pair / clear commands on a
//                valid/ready channel, drives the file's address, data and write
//                enable ports, and returns read data on a valid/ready response
//                channel.
//                Optional feature macro: REGACC_ZERO_PROTECT_EN
//                  (writes to address 0 are dropped and flagged on Err).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic [1:0]        Cmd_Op,
    input  logic [ADDR_W-1:0] Cmd_Addr_A,
    input  logic [ADDR_W-1:0] Cmd_Addr_B,
    input  logic [DATA_W-1:0] Cmd_Data,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] Rsp_Data_A,
    output logic [DATA_W-1:0] Rsp_Data_B,
    output logic              Busy,
    output logic              Err,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              Write_Reg,
    output logic [DATA_W-1:0] W_Data,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RSP  = 3'd3,
        ST_CLR  = 3'd4
    } state_t;

    localparam logic [1:0]        c_op_write = 2'b01;
    localparam logic [1:0]        c_op_read  = 2'b10;
    localparam logic [1:0]        c_op_clear = 2'b11;
    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_zero_blk;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [DATA_W-1:0]   r_w_data;
    logic                r_write_reg;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data_a;
    logic [DATA_W-1:0]   r_rsp_data_b;

    assign w_accept = Cmd_Valid && (r_state == ST_IDLE);

`ifdef REGACC_ZERO_PROTECT_EN
    logic r_err;

    // A write aimed at address 0 is swallowed; Err flags it for one cycle.
    assign w_zero_blk = (Cmd_Addr_A == '0);

    // Err pulse for the cycle following a rejected accept.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (Cmd_Op == c_op_write) && w_zero_blk;
        end
    end

    assign Err = r_err;
`else
    assign w_zero_blk = 1'b0;
    assign Err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (Cmd_Op)
                        c_op_write: if (!w_zero_blk) w_state_nxt = ST_WR;
                        c_op_read:  w_state_nxt = ST_RD;
                        c_op_clear: w_state_nxt = ST_CLR;
                        default:    w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WR:   w_state_nxt = ST_IDLE;
            ST_RD:   w_state_nxt = ST_RSP;
            ST_RSP:  if (Rsp_Ready) w_state_nxt = ST_IDLE;
            ST_CLR:  if (r_clr_cnt == c_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered register-file port, response channel and clear counter.
    // W_Addr tracks the clear counter so each CLR cycle writes its own slot.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_clr_cnt    <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_w_addr     <= '0;
            r_w_data     <= '0;
            r_write_reg  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data_a <= '0;
            r_rsp_data_b <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (Cmd_Op)
                            c_op_write: begin
                                if (!w_zero_blk) begin
                                    r_write_reg <= 1'b1;
                                    r_w_addr    <= Cmd_Addr_A;
                                    r_w_data    <= Cmd_Data;
                                end
                            end
                            c_op_read: begin
                                r_addr_a <= Cmd_Addr_A;
                                r_addr_b <= Cmd_Addr_B;
                            end
                            c_op_clear: begin
                                r_clr_cnt   <= '0;
                                r_w_addr    <= '0;
                                r_w_data    <= '0;
                                r_write_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WR: begin
                    r_write_reg <= 1'b0;
                end
                ST_RD: begin
                    r_rsp_data_a <= R_Data_A;
                    r_rsp_data_b <= R_Data_B;
                    r_rsp_valid  <= 1'b1;
                end
                ST_RSP: begin
                    if (Rsp_Ready) r_rsp_valid <= 1'b0;
                end
                ST_CLR: begin
                    if (r_clr_cnt == c_last) begin
                        r_write_reg <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_one;
                        r_w_addr  <= r_clr_cnt + c_one;
                    end
                end
                default: begin
                    r_write_reg <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Cmd_Ready  = (r_state == ST_IDLE);
    assign Busy       = (r_state != ST_IDLE);
    assign Rsp_Valid  = r_rsp_valid;
    assign Rsp_Data_A = r_rsp_data_a;
    assign Rsp_Data_B = r_rsp_data_b;
    assign R_Addr_A   = r_addr_a;
    assign R_Addr_B   = r_addr_b;
    assign W_Addr     = r_w_addr;
    assign W_Data     = r_w_data;
    assign Write_Reg  = r_write_reg;

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_access_ctrl
//  Description : Self-checking bench for regfile_access_ctrl with a behavioural
//                register file and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Cmd_Valid = 1'b0;
    logic          Cmd_Ready;
    logic [1:0]    Cmd_Op = 2'b00;
    logic [AW-1:0] Cmd_Addr_A = '0;
    logic [AW-1:0] Cmd_Addr_B = '0;
    logic [DW-1:0] Cmd_Data = '0;
    logic          Rsp_Valid;
    logic          Rsp_Ready = 1'b0;
    logic [DW-1:0] Rsp_Data_A;
    logic [DW-1:0] Rsp_Data_B;
    logic          Busy;
    logic          Err;
    logic [AW-1:0] R_Addr_A;
    logic [AW-1:0] R_Addr_B;
    logic [AW-1:0] W_Addr;
    logic          Write_Reg;
    logic [DW-1:0] W_Data;
    logic [DW-1:0] R_Data_A;
    logic [DW-1:0] R_Data_B;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [2*DW-1:0] sb[$];
    logic [2*DW-1:0] sb_exp;

    // Behavioural register file: combinational reads, commit on rising edge.
    logic [DW-1:0] rf [NR];
    assign R_Data_A = rf[R_Addr_A];
    assign R_Data_B = rf[R_Addr_B];
    always @(posedge Clk) if (Write_Reg) rf[W_Addr] <= W_Data;

    always #5 Clk = ~Clk;

    regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .Clk(Clk), .Reset(Reset),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
        .Cmd_Addr_A(Cmd_Addr_A), .Cmd_Addr_B(Cmd_Addr_B), .Cmd_Data(Cmd_Data),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Rsp_Data_A(Rsp_Data_A), .Rsp_Data_B(Rsp_Data_B),
        .Busy(Busy), .Err(Err),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
        .Write_Reg(Write_Reg), .W_Data(W_Data),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B)
    );

    // Scoreboard: compare every response handshake against the queued expectation.
    always @(negedge Clk) begin
        if (Reset && Rsp_Valid && Rsp_Ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got A=%h B=%h, required no response", Rsp_Data_A, Rsp_Data_B);
            end else begin
                sb_exp = sb.pop_front();
                if ({Rsp_Data_A, Rsp_Data_B} !== sb_exp) begin
                    n_fail++;
                    $display("FAIL rsp_data: got A=%h B=%h, required A=%h B=%h",
                             Rsp_Data_A, Rsp_Data_B, sb_exp[2*DW-1:DW], sb_exp[DW-1:0]);
                end
            end
        end
    end

    // Present a command just after a rising edge; returns just after the accept edge.
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                            input logic [AW-1:0] b, input logic [DW-1:0] d);
        int n;
        n = 0;
        Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Addr_A = a; Cmd_Addr_B = b; Cmd_Data = d;
        @(negedge Clk);
        while (!Cmd_Ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        n_checks++;
        if (!Cmd_Ready) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout: Cmd_Ready=%b, required 1 within 100 cycles", Cmd_Ready);
        end
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
    endtask

    // Issue a read pair, queue its expected data, and complete the handshake.
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        int n;
        n = 0;
        sb.push_back({ea, eb});
        send_cmd(2'b10, a, b, '0);
        while (!Rsp_Valid && n < 10) begin
            @(posedge Clk); #1;
            n++;
        end
        n_checks++;
        if (!Rsp_Valid) begin
            n_fail++;
            $display("FAIL rsp_timeout: Rsp_Valid=%b, required 1 within 10 cycles", Rsp_Valid);
        end
        Rsp_Ready = 1'b1;
        @(posedge Clk); #1;
        Rsp_Ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({Write_Reg, W_Addr, W_Data, R_Addr_A, R_Addr_B} !== '0) begin
            n_fail++;
            $display("FAIL reset_rf_port: got WE=%b WA=%h WD=%h RA=%h RB=%h, required all 0",
                     Write_Reg, W_Addr, W_Data, R_Addr_A, R_Addr_B);
        end
        n_checks++;
        if ({Rsp_Valid, Rsp_Data_A, Rsp_Data_B, Err} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got V=%b A=%h B=%h Err=%b, required all 0",
                     Rsp_Valid, Rsp_Data_A, Rsp_Data_B, Err);
        end
        n_checks++;
        if (Cmd_Ready !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got Cmd_Ready=%b Busy=%b, required 1/0", Cmd_Ready, Busy);
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_write();
        send_cmd(2'b01, 5'd1, 5'd0, 32'h1111_1111);
        @(negedge Clk);
        n_checks++;
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd1 || W_Data !== 32'h1111_1111 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_pulse: got WE=%b WA=%h WD=%h Busy=%b, required 1/01/11111111/1",
                     Write_Reg, W_Addr, W_Data, Busy);
        end
        @(negedge Clk);
        n_checks++;
        if (Write_Reg !== 1'b0 || Busy !== 1'b0 || Cmd_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_end: got WE=%b Busy=%b Rdy=%b, required 0/0/1", Write_Reg, Busy, Cmd_Ready);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_read_pair();
        send_cmd(2'b01, 5'd2, 5'd0, 32'h2222_2222);
        sb.push_back({32'h1111_1111, 32'h2222_2222});
        send_cmd(2'b10, 5'd1, 5'd2, '0);
        @(negedge Clk);
        n_checks++;
        if (Rsp_Valid !== 1'b0 || R_Addr_A !== 5'd1 || R_Addr_B !== 5'd2 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_rd_state: got V=%b RA=%h RB=%h Busy=%b, required 0/01/02/1",
                     Rsp_Valid, R_Addr_A, R_Addr_B, Busy);
        end
        @(negedge Clk);
        n_checks++;
        if (Rsp_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_latency: got Rsp_Valid=%b, required 1", Rsp_Valid);
        end
        @(posedge Clk); #1;
        Rsp_Ready = 1'b1;
        @(posedge Clk); #1;
        Rsp_Ready = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Rsp_Valid !== 1'b0 || Busy !== 1'b0 || Rsp_Data_A !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL read_release: got V=%b Busy=%b A=%h, required 0/0/11111111",
                     Rsp_Valid, Busy, Rsp_Data_A);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_back_pressure();
        sb.push_back({32'h1111_1111, 32'h2222_2222});
        send_cmd(2'b10, 5'd1, 5'd2, '0);
        @(posedge Clk); #1;
        Cmd_Valid = 1'b1; Cmd_Op = 2'b01; Cmd_Addr_A = 5'd3; Cmd_Data = 32'h3333_3333;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Rsp_Valid !== 1'b1 || Rsp_Data_A !== 32'h1111_1111 || Rsp_Data_B !== 32'h2222_2222 ||
                Cmd_Ready !== 1'b0 || Write_Reg !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got V=%b A=%h B=%h Rdy=%b WE=%b, required 1/11111111/22222222/0/0",
                         i, Rsp_Valid, Rsp_Data_A, Rsp_Data_B, Cmd_Ready, Write_Reg);
            end
        end
        @(posedge Clk); #1;
        Rsp_Ready = 1'b1;
        @(posedge Clk); #1;
        Rsp_Ready = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Rsp_Valid !== 1'b0 || Cmd_Ready !== 1'b1 || Write_Reg !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got V=%b Rdy=%b WE=%b, required 0/1/0", Rsp_Valid, Cmd_Ready, Write_Reg);
        end
        @(posedge Clk); #1;
        Cmd_Valid = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd3 || W_Data !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL stall_held_write: got WE=%b WA=%h WD=%h, required 1/03/33333333",
                     Write_Reg, W_Addr, W_Data);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_clear();
        send_cmd(2'b11, 5'd0, 5'd0, '0);
        for (int i = 0; i < NR; i++) begin
            @(negedge Clk);
            n_checks++;
            if (Write_Reg !== 1'b1 || W_Addr !== AW'(i) || W_Data !== '0 || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_sweep[%0d]: got WE=%b WA=%h WD=%h Busy=%b, required 1/%h/0/1",
                         i, Write_Reg, W_Addr, W_Data, Busy, AW'(i));
            end
        end
        @(negedge Clk);
        n_checks++;
        if (Write_Reg !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_end: got WE=%b Busy=%b, required 0/0", Write_Reg, Busy);
        end
        @(posedge Clk); #1;
        do_read(5'd1, 5'd2, 32'h0, 32'h0);
    endtask

    task automatic test_reset_during_clear();
        int n;
        n = 0;
        send_cmd(2'b01, 5'd6,  5'd0, 32'h6666_6666);
        send_cmd(2'b01, 5'd7,  5'd0, 32'h7777_7777);
        send_cmd(2'b01, 5'd8,  5'd0, 32'h8888_8888);
        send_cmd(2'b01, 5'd31, 5'd0, 32'h3131_3131);
        send_cmd(2'b11, 5'd0,  5'd0, '0);
        @(negedge Clk);
        while (W_Addr !== 5'd7 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        n_checks++;
        if (W_Addr !== 5'd7 || Write_Reg !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_reach7: got WA=%h WE=%b, required 07/1", W_Addr, Write_Reg);
        end
        #1 Reset = 1'b0;
        #1;
        n_checks++;
        if (Write_Reg !== 1'b0 || Busy !== 1'b0 || Cmd_Ready !== 1'b1 || W_Addr !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset: got WE=%b Busy=%b Rdy=%b WA=%h, required 0/0/1/00",
                     Write_Reg, Busy, Cmd_Ready, W_Addr);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        do_read(5'd6, 5'd7,  32'h0,         32'h7777_7777);
        do_read(5'd8, 5'd31, 32'h8888_8888, 32'h3131_3131);
    endtask

    task automatic test_zero_addr();
        send_cmd(2'b01, 5'd0, 5'd0, 32'hDEAD_BEEF);
        @(negedge Clk);
        n_checks++;
`ifdef REGACC_ZERO_PROTECT_EN
        if (Write_Reg !== 1'b0 || Err !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_protect: got WE=%b Err=%b Busy=%b, required 0/1/0", Write_Reg, Err, Busy);
        end
`else
        if (Write_Reg !== 1'b1 || W_Addr !== 5'd0 || W_Data !== 32'hDEAD_BEEF || Err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_write: got WE=%b WA=%h WD=%h Err=%b, required 1/00/deadbeef/0",
                     Write_Reg, W_Addr, W_Data, Err);
        end
`endif
        @(negedge Clk);
        n_checks++;
        if (Err !== 1'b0 || Write_Reg !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: got Err=%b WE=%b, required 0/0", Err, Write_Reg);
        end
        @(posedge Clk); #1;
`ifdef REGACC_ZERO_PROTECT_EN
        do_read(5'd0, 5'd7, 32'h0, 32'h7777_7777);
`else
        do_read(5'd0, 5'd7, 32'hDEAD_BEEF, 32'h7777_7777);
`endif
    endtask

    task automatic test_nop();
        send_cmd(2'b00, 5'd5, 5'd6, 32'h5555_5555);
        @(negedge Clk);
        n_checks++;
        if (Busy !== 1'b0 || Write_Reg !== 1'b0 || Rsp_Valid !== 1'b0 || R_Addr_A !== 5'd0 || R_Addr_B !== 5'd7) begin
            n_fail++;
            $display("FAIL nop: got Busy=%b WE=%b V=%b RA=%h RB=%h, required 0/0/0/00/07",
                     Busy, Write_Reg, Rsp_Valid, R_Addr_A, R_Addr_B);
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_pair();
        test_back_pressure();
        test_clear();
        test_reset_during_clear();
        test_zero_addr();
        test_nop();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
